div_clk_enable_mc: RTL and testbench

Multi-channel programmable clock-enable generator; parametrised successor of the single-channel symmetric enable divider.
- Each channel produces a registered enable level with independent high/low lengths (duty control), a start-phase offset, and per-channel start/stop.
- Configuration updates are shadowed and glitch-free, applied only at period boundaries.
- Feeds column/pixel timing (e.g. flag_col generation) from the main clk domain.

---
 rtl/div_clk_enable_mc_pkg.sv | 13 +
 rtl/div_clk_enable_ch.sv | 144 ++++++++++++++
 rtl/div_clk_enable_mc.sv | 55 +++++
 tb/tb_div_clk_enable_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_enable_mc_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// channel FSM encoding and default field widths.
package div_clk_enable_mc_pkg;
  localparam int RATIO_W_DEF = 16;
  localparam int CNT_W_DEF   = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } st_t;
endpackage

// File: rtl/div_clk_enable_ch.sv
// One enable channel: DELAY/HIGH/LOW sequencer with active and pending
// configuration; new settings take effect only at period boundaries.
module div_clk_enable_ch
  import div_clk_enable_mc_pkg::*;
#(
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic               sync_start,
  input  logic [RATIO_W-1:0] hi_in,
  input  logic [RATIO_W-1:0] lo_in,
  input  logic [RATIO_W-1:0] ph_in,
  output logic               clk_enable,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic               pend,
  output logic [CNT_W-1:0]   cnt
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  st_t              st, st_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [RATIO_W-1:0] act_hi, act_lo, act_ph;
  logic [RATIO_W-1:0] pnd_hi, pnd_lo, pnd_ph;
  logic [RATIO_W-1:0] new_hi, new_lo, new_ph;
  logic pnd_nx, bnd, ce_nx, rise_nx, fall_nx;

  // Last LOW cycle of a running channel: the period boundary.
  assign bnd = (st == ST_LOW) && en && (cnt == CNT_W'(act_lo));

  // Config selection: a load landing on an apply point bypasses the shadow.
  always_comb begin
    new_hi = act_hi;
    new_lo = act_lo;
    new_ph = act_ph;
    pnd_nx = pend | load;
    if (sync_start || bnd) begin
      if (load) begin
        new_hi = hi_in;
        new_lo = lo_in;
        new_ph = ph_in;
      end else if (pend) begin
        new_hi = pnd_hi;
        new_lo = pnd_lo;
        new_ph = pnd_ph;
      end
      pnd_nx = 1'b0;
    end else if ((st == ST_IDLE) && pend) begin
      new_hi = pnd_hi;
      new_lo = pnd_lo;
      new_ph = pnd_ph;
      pnd_nx = load;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt + ONE;
    if (sync_start) begin
      cnt_nx = '0;
      if (!en)                st_nx = ST_IDLE;
      else if (new_ph == '0)  st_nx = ST_HIGH;
      else                    st_nx = ST_DELAY;
    end else begin
      unique case (st)
        ST_IDLE: begin
          cnt_nx = '0;
          if (en) st_nx = (new_ph == '0) ? ST_HIGH : ST_DELAY;
        end
        ST_DELAY: begin
          if (!en) begin
            st_nx  = ST_IDLE;
            cnt_nx = '0;
          end else if (cnt + ONE == CNT_W'(act_ph)) begin
            st_nx  = ST_HIGH;
            cnt_nx = '0;
          end
        end
        // A high phase always runs to completion, even once en drops.
        ST_HIGH: begin
          if (cnt == CNT_W'(act_hi)) begin
            st_nx  = en ? ST_LOW : ST_IDLE;
            cnt_nx = '0;
          end
        end
        ST_LOW: begin
          if (!en) begin
            st_nx  = ST_IDLE;
            cnt_nx = '0;
          end else if (bnd) begin
            st_nx  = ST_HIGH;
            cnt_nx = '0;
          end
        end
        default: begin
          st_nx  = ST_IDLE;
          cnt_nx = '0;
        end
      endcase
    end
  end

  always_comb begin
    ce_nx   = (st_nx == ST_HIGH);
    rise_nx = (st_nx == ST_HIGH) && ((st != ST_HIGH) || sync_start);
    fall_nx = (st == ST_HIGH) && (st_nx != ST_HIGH) && !sync_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      cnt        <= '0;
      act_hi     <= '0;
      act_lo     <= '0;
      act_ph     <= '0;
      pnd_hi     <= '0;
      pnd_lo     <= '0;
      pnd_ph     <= '0;
      pend       <= 1'b0;
      clk_enable <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      st         <= st_nx;
      cnt        <= cnt_nx;
      act_hi     <= new_hi;
      act_lo     <= new_lo;
      act_ph     <= new_ph;
      pend       <= pnd_nx;
      clk_enable <= ce_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
      if (load) begin
        pnd_hi <= hi_in;
        pnd_lo <= lo_in;
        pnd_ph <= ph_in;
      end
    end
  end
endmodule

// File: rtl/div_clk_enable_mc.sv
// Multi-channel clock-enable generator: fans load/sync_start out to the
// channel array and raises cfg_ack once every channel has taken its config.
module div_clk_enable_mc
  import div_clk_enable_mc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH*RATIO_W-1:0] ratio_hi,
  input  logic [NUM_CH*RATIO_W-1:0] ratio_lo,
  input  logic [NUM_CH*RATIO_W-1:0] phase,
  input  logic                      load,
  input  logic                      sync_start,
  output logic [NUM_CH-1:0]         clk_enable,
  output logic [NUM_CH-1:0]         rise_pulse,
  output logic [NUM_CH-1:0]         fall_pulse,
  output logic                      cfg_ack,
  output logic [NUM_CH*CNT_W-1:0]   cnt_clk_enable
);
  logic [NUM_CH-1:0] pend;
  logic              pend_any_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    div_clk_enable_ch #(.RATIO_W(RATIO_W), .CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[i]),
      .load       (load),
      .sync_start (sync_start),
      .hi_in      (ratio_hi[i*RATIO_W +: RATIO_W]),
      .lo_in      (ratio_lo[i*RATIO_W +: RATIO_W]),
      .ph_in      (phase[i*RATIO_W +: RATIO_W]),
      .clk_enable (clk_enable[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .pend       (pend[i]),
      .cnt        (cnt_clk_enable[i*CNT_W +: CNT_W])
    );
  end

  // Ack fires on the falling edge of "any channel still pending".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_any_q <= 1'b0;
      cfg_ack    <= 1'b0;
    end else begin
      pend_any_q <= |pend;
      cfg_ack    <= pend_any_q & ~(|pend);
    end
  end
endmodule

// File: tb/tb_div_clk_enable_mc.sv
// Self-checking bench: per-cycle comparison against a period-position model
// plus directed scenario checks.
module tb_div_clk_enable_mc;
  localparam int NC = 4, RW = 16, CW = 18;
  localparam int OW = 3*NC + 1 + NC*CW;

  logic clk = 1'b0, rst_n;
  logic [NC-1:0] en, clk_enable, rise_pulse, fall_pulse;
  logic [NC*RW-1:0] ratio_hi, ratio_lo, phase;
  logic load, sync_start, cfg_ack;
  logic [NC*CW-1:0] cnt_clk_enable;
  logic [OW-1:0] obs, exp_v;
  int vecs = 0, errs = 0, cyc = 0;

  div_clk_enable_mc #(.NUM_CH(NC), .RATIO_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ratio_hi(ratio_hi), .ratio_lo(ratio_lo),
    .phase(phase), .load(load), .sync_start(sync_start), .clk_enable(clk_enable),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .cfg_ack(cfg_ack),
    .cnt_clk_enable(cnt_clk_enable));

  always #5 clk = ~clk;
  assign obs = {clk_enable, rise_pulse, fall_pulse, cfg_ack, cnt_clk_enable};

  // Model: each running channel is a remaining delay d, then a position t
  // within the period (0..hi is high, hi+1..hi+lo+1 is low).
  int m_on[NC], m_d[NC], m_t[NC], m_flag[NC];
  int m_hi[NC], m_lo[NC], m_ph[NC], p_hi[NC], p_lo[NC], p_ph[NC];
  bit [NC-1:0] m_ce, m_rise, m_fall;
  bit m_ack, m_anyp;
  logic [NC*CW-1:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_on[i] = 0; m_d[i] = 0; m_t[i] = 0; m_flag[i] = 0;
      m_hi[i] = 0; m_lo[i] = 0; m_ph[i] = 0; p_hi[i] = 0; p_lo[i] = 0; p_ph[i] = 0;
    end
    m_ce = '0; m_rise = '0; m_fall = '0; m_ack = 0; m_anyp = 0; m_cnt = '0;
    exp_v = '0;
  endtask

  task automatic set_active(int i, bit use_in);
    if (use_in) begin
      m_hi[i] = int'(ratio_hi[i*RW +: RW]);
      m_lo[i] = int'(ratio_lo[i*RW +: RW]);
      m_ph[i] = int'(phase[i*RW +: RW]);
    end else begin
      m_hi[i] = p_hi[i]; m_lo[i] = p_lo[i]; m_ph[i] = p_ph[i];
    end
  endtask

  task automatic start_ch(int i);
    m_on[i] = 1; m_d[i] = m_ph[i]; m_t[i] = 0;
  endtask

  task automatic model_step();
    bit any_cur;
    int c;
    any_cur = 0;
    for (int i = 0; i < NC; i++) if (m_flag[i] != 0) any_cur = 1;
    m_ack = m_anyp & ~any_cur;
    m_anyp = any_cur;
    for (int i = 0; i < NC; i++) begin
      bit oh, nh, fresh, byp;
      oh = m_on[i] != 0 && m_d[i] == 0 && m_t[i] <= m_hi[i];
      fresh = 0; byp = 0;
      if (sync_start) begin
        if (m_flag[i] != 0 || load) set_active(i, load);
        byp = 1;
        if (en[i]) begin start_ch(i); fresh = (m_d[i] == 0); end
        else m_on[i] = 0;
      end else if (m_on[i] == 0) begin
        if (m_flag[i] != 0) begin set_active(i, 0); m_flag[i] = 0; end
        if (en[i]) begin start_ch(i); fresh = (m_d[i] == 0); end
      end else if (m_d[i] > 0) begin
        if (!en[i]) m_on[i] = 0;
        else begin m_d[i]--; fresh = (m_d[i] == 0); end
      end else if (m_t[i] <= m_hi[i]) begin
        if (m_t[i] < m_hi[i] || en[i]) m_t[i]++;
        else m_on[i] = 0;
      end else if (!en[i]) begin
        m_on[i] = 0;
      end else if (m_t[i] == m_hi[i] + m_lo[i] + 1) begin
        if (m_flag[i] != 0 || load) set_active(i, load);
        byp = 1; m_t[i] = 0; fresh = 1;
      end else m_t[i]++;
      if (byp) m_flag[i] = 0;
      else if (load) m_flag[i] = 1;
      if (load) begin
        p_hi[i] = int'(ratio_hi[i*RW +: RW]);
        p_lo[i] = int'(ratio_lo[i*RW +: RW]);
        p_ph[i] = int'(phase[i*RW +: RW]);
      end
      nh = m_on[i] != 0 && m_d[i] == 0 && m_t[i] <= m_hi[i];
      m_ce[i] = nh; m_rise[i] = nh && fresh; m_fall[i] = oh && !nh && !sync_start;
      if (m_on[i] == 0)    c = 0;
      else if (m_d[i] > 0) c = m_ph[i] - m_d[i];
      else if (nh)         c = m_t[i];
      else                 c = m_t[i] - m_hi[i] - 1;
      m_cnt[i*CW +: CW] = CW'(c);
    end
    exp_v = {m_ce, m_rise, m_fall, m_ack, m_cnt};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic cfg(int ch, int hi, int lo, int ph);
    ratio_hi[ch*RW +: RW] = RW'(hi);
    ratio_lo[ch*RW +: RW] = RW'(lo);
    phase[ch*RW +: RW]    = RW'(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = '0; load = 0; sync_start = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic pulse_load();
    load = 1; tick(); load = 0;
  endtask

  task automatic test_reset();
    en = '0; load = 0; sync_start = 0; ratio_hi = '0; ratio_lo = '0; phase = '0;
    rst_n = 1; #1 rst_n = 0; #1;
    model_reset();
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_state got %h exp 0", obs); end
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL reset_idle cyc %0d got %h exp %h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_symmetric();
    int r[$];
    int d;
    do_reset();
    cfg(0, 3, 3, 0); pulse_load();
    en[0] = 1;
    for (int k = 0; k < 30; k++) begin
      tick(); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL symmetric cyc %0d got %h exp %h", cyc, obs, exp_v); end
      if (rise_pulse[0]) r.push_back(k);
    end
    d = (r.size() >= 2) ? r[1] - r[0] : -1;
    vecs++;
    if (d !== 8) begin errs++; $display("FAIL symmetric_period got %0d exp 8", d); end
  endtask

  task automatic test_duty_phase();
    do_reset();
    cfg(1, 1, 5, 3); pulse_load();
    en[1] = 1;
    for (int k = 0; k < 30; k++) begin
      tick(); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL duty_phase cyc %0d got %h exp %h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_load_midhigh();
    int acks, run, best;
    do_reset();
    cfg(0, 3, 3, 0); pulse_load();
    en[0] = 1; tick(); tick();
    cfg(0, 9, 3, 0);
    acks = 0; run = 0; best = 0;
    load = 1;
    for (int k = 0; k < 40; k++) begin
      tick(); load = 0; vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL load_midhigh cyc %0d got %h exp %h", cyc, obs, exp_v); end
      if (cfg_ack) acks++;
      run = clk_enable[0] ? run + 1 : 0;
      if (run > best) best = run;
    end
    vecs++;
    if (acks !== 1) begin errs++; $display("FAIL load_ack_count got %0d exp 1", acks); end
    vecs++;
    if (best !== 10) begin errs++; $display("FAIL load_new_high got %0d exp 10", best); end
  endtask

  task automatic test_en_drop();
    int highs;
    do_reset();
    cfg(0, 3, 3, 0); pulse_load();
    en[0] = 1; tick(); highs = clk_enable[0] ? 1 : 0;
    tick(); if (clk_enable[0]) highs++;
    en[0] = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL en_drop_high cyc %0d got %h exp %h", cyc, obs, exp_v); end
      if (clk_enable[0]) highs++;
    end
    vecs++;
    if (highs !== 4) begin errs++; $display("FAIL en_drop_hold got %0d exp 4", highs); end
    en[0] = 1;
    for (int k = 0; k < 6; k++) tick();
    en[0] = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL en_drop_low cyc %0d got %h exp %h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_sync_start();
    int r0, r2;
    do_reset();
    cfg(0, 2, 2, 0); cfg(2, 1, 3, 2); cfg(1, 4, 4, 0); cfg(3, 0, 0, 0);
    pulse_load();
    en = 4'b0101;
    for (int k = 0; k < 7; k++) tick();
    r0 = -1; r2 = -1;
    sync_start = 1;
    for (int k = 0; k < 10; k++) begin
      tick(); sync_start = 0; vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL sync_start cyc %0d got %h exp %h", cyc, obs, exp_v); end
      if (rise_pulse[0] && r0 < 0) r0 = k;
      if (rise_pulse[2] && r2 < 0) r2 = k;
    end
    vecs++;
    if (r2 - r0 !== 2 || r0 !== 0) begin errs++; $display("FAIL sync_offset got %0d/%0d exp 0/2", r0, r2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) en[$urandom_range(NC-1)] = ~en[$urandom_range(NC-1)];
      if ($urandom_range(11) == 0) begin
        load = 1;
        for (int i = 0; i < NC; i++)
          cfg(i, $urandom_range(5), $urandom_range(5), $urandom_range(4));
      end
      sync_start = ($urandom_range(39) == 0);
      tick(); load = 0; sync_start = 0; vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL random cyc %0d got %h exp %h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    int acks;
    do_reset();
    cfg(0, 3, 3, 0); pulse_load();
    en[0] = 1; tick(); tick();
    cfg(0, 7, 7, 0); pulse_load();
    #2 rst_n = 0; #1;
    model_reset();
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL async_reset got %h exp 0", obs); end
    @(negedge clk); rst_n = 1;
    cfg(0, 5, 5, 5);
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      tick(); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL post_reset cyc %0d got %h exp %h", cyc, obs, exp_v); end
      if (cfg_ack) acks++;
    end
    vecs++;
    if (acks !== 0) begin errs++; $display("FAIL post_reset_ack got %0d exp 0", acks); end
  endtask

  initial begin
    test_reset();
    test_symmetric();
    test_duty_phase();
    test_load_midhigh();
    test_en_drop();
    test_sync_start();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
